// File: rtl/frame_buffer_dp.sv
// Single-port-write / single-port-read frame buffer with auto-increment write pointer,
// a hardware clear sweep, write-first read bypass and a sticky out-of-range flag.
module frame_buffer_dp #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 17,
  parameter int                DEPTH    = 76800,
  parameter logic [DATA_W-1:0] INIT_VAL = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              regwrite,
  input  logic              wr_auto,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              regread,
  input  logic [ADDR_W-1:0] addr_out,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  input  logic              clr,
  output logic              busy,
  output logic              frame_done,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic              err
);

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE_C   = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
  logic                rd_valid_q, rd_valid_d;
  logic                frame_done_q, frame_done_d;
  logic                err_q, err_d;
  // data_out is either the synchronous memory read or the hold register (bypass / zero / hold)
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic                sel_mem_q, sel_mem_d;
  logic [DATA_W-1:0]   mem_rd_q;
  logic                mem_rd_s;
  logic                we_s;
  logic [ADDR_W-1:0]   waddr_s;
  logic [DATA_W-1:0]   wdata_s;
  logic [DATA_W-1:0]   mem_q [0:DEPTH-1];

  // Next-state, write-port selection and read-path decisions
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    clr_ptr_d    = clr_ptr_q;
    frame_done_d = 1'b0;
    err_d        = err_q;
    we_s         = 1'b0;
    waddr_s      = wr_ptr_q;
    wdata_s      = data_in;
    rd_valid_d   = regread;
    hold_d       = hold_q;
    sel_mem_d    = sel_mem_q;
    mem_rd_s     = 1'b0;

    case (state_q)
      ST_CLEAR: begin
        we_s    = 1'b1;
        waddr_s = clr_ptr_q;
        wdata_s = INIT_VAL;
        if (clr_ptr_q == LAST_C) begin
          state_d   = ST_IDLE;
          clr_ptr_d = {ADDR_W{1'b0}};
        end else begin
          clr_ptr_d = clr_ptr_q + ONE_C;
        end
      end
      ST_IDLE: begin
        if (clr) begin
          state_d   = ST_CLEAR;
          clr_ptr_d = {ADDR_W{1'b0}};
        end else if (regwrite && wr_auto) begin
          we_s         = 1'b1;
          waddr_s      = wr_ptr_q;
          frame_done_d = (wr_ptr_q == LAST_C);
          if (wr_ptr_q == LAST_C) begin
            wr_ptr_d = {ADDR_W{1'b0}};
          end else begin
            wr_ptr_d = wr_ptr_q + ONE_C;
          end
        end else if (regwrite) begin
          if ({1'b0, addr_in} < DEPTH_C) begin
            we_s    = 1'b1;
            waddr_s = addr_in;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          we_s = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Write-first: a same-cycle write to the read address is forwarded
    if (regread) begin
      if ({1'b0, addr_out} >= DEPTH_C) begin
        hold_d    = {DATA_W{1'b0}};
        sel_mem_d = 1'b0;
        err_d     = 1'b1;
      end else if (we_s && (waddr_s == addr_out)) begin
        hold_d    = wdata_s;
        sel_mem_d = 1'b0;
      end else begin
        sel_mem_d = 1'b1;
        mem_rd_s  = 1'b1;
      end
    end else begin
      sel_mem_d = sel_mem_q;
    end
  end

  // Control and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= {ADDR_W{1'b0}};
      clr_ptr_q    <= {ADDR_W{1'b0}};
      rd_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      hold_q       <= {DATA_W{1'b0}};
      sel_mem_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      clr_ptr_q    <= clr_ptr_d;
      rd_valid_q   <= rd_valid_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
      hold_q       <= hold_d;
      sel_mem_q    <= sel_mem_d;
    end
  end

  // Storage array; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (we_s && !rst) begin
      mem_q[waddr_s] <= wdata_s;
    end
    if (mem_rd_s) begin
      mem_rd_q <= mem_q[addr_out];
    end
  end

  assign data_out   = sel_mem_q ? mem_rd_q : hold_q;
  assign rd_valid   = rd_valid_q;
  assign busy       = (state_q == ST_CLEAR);
  assign frame_done = frame_done_q;
  assign wr_ptr     = wr_ptr_q;
  assign err        = err_q;

endmodule

// File: doc/frame_buffer_dp.md
FRAME_BUFFER_DP -- requirements
Module: frame_buffer_dp

Interface
REQ-001 Parameter DATA_W, default 16, pixel word width in bits.
REQ-002 Parameter ADDR_W, default 17, address width in bits.
REQ-003 Parameter DEPTH, default 76800, number of stored words (320x240); DEPTH <= 2^ADDR_W.
REQ-004 Parameter INIT_VAL, default 0, word written by the clear sweep.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 regwrite  in  1  write request, one word per cycle while high.
REQ-008 wr_auto  in  1  1: write address from internal pointer; 0: from addr_in.
REQ-009 addr_in  in  ADDR_W  explicit write address (wr_auto=0).
REQ-010 data_in  in  DATA_W  write data.
REQ-011 regread  in  1  read request.
REQ-012 addr_out  in  ADDR_W  read address.
REQ-013 data_out  out  DATA_W  registered read data.
REQ-014 rd_valid  out  1  data_out valid for the request of the previous cycle.
REQ-015 clr  in  1  single-cycle pulse; starts clear sweep.
REQ-016 busy  out  1  clear sweep in progress.
REQ-017 frame_done  out  1  one-cycle pulse on auto-write of address DEPTH-1.
REQ-018 wr_ptr  out  ADDR_W  current auto-write pointer.
REQ-019 err  out  1  sticky out-of-range access flag.

Function
REQ-020 FSM states IDLE, CLEAR; IDLE -> CLEAR on clr=1 in IDLE; CLEAR -> IDLE in the cycle after address DEPTH-1 is written.
REQ-021 CLEAR: writes INIT_VAL to addresses 0..DEPTH-1, one per cycle, ascending; sweep lasts exactly DEPTH cycles; busy=1 throughout.
REQ-022 During CLEAR: regwrite ignored, wr_ptr held, clr ignored; reads still serviced.
REQ-023 IDLE, regwrite=1, wr_auto=0: mem[addr_in] <= data_in at the edge.
REQ-024 IDLE, regwrite=1, wr_auto=1: mem[wr_ptr] <= data_in; wr_ptr <= wr_ptr+1, or 0 when wr_ptr = DEPTH-1 (wrap).
REQ-025 frame_done = 1 in the cycle after the auto-write at DEPTH-1; 0 otherwise.
REQ-026 Explicit writes (wr_auto=0) do not change wr_ptr.
REQ-027 Read latency 1 cycle: regread=1 at edge N -> data_out and rd_valid=1 after edge N+1.
REQ-028 regread=0: rd_valid=0, data_out holds last value.
REQ-029 Read and write to same address in same cycle: write-first; data_out returns new data (includes clear-sweep writes).
REQ-030 Write address >= DEPTH (wr_auto=0): write dropped, err <= 1.
REQ-031 Read address >= DEPTH: data_out <= 0, rd_valid=1, err <= 1.
REQ-032 err cleared only by rst.
REQ-033 clr and regwrite same cycle in IDLE: clr wins, write dropped.

Reset
REQ-034 rst=1 at an edge: state IDLE, wr_ptr=0, data_out=0, rd_valid=0, busy=0, frame_done=0, err=0.
REQ-035 rst has priority over all inputs; asserted mid-CLEAR aborts the sweep (partially cleared contents remain).
REQ-036 Memory array contents not affected by rst.

Verification
REQ-037 Explicit: write 16'hAAAA@0, 16'h8642@1, 16'hFFFF@2, 16'hAAAF@3; read 3,1,0 -> data_out AAAF, 8642, AAAA one cycle after each request, rd_valid=1.
REQ-038 Auto: rst, then DEPTH auto-writes of data=index -> wr_ptr wraps to 0, frame_done exactly one pulse after write DEPTH-1, mem[76799]=76799 mod 2^16.
REQ-039 Bypass: write 16'h1234@5 while reading 5 same cycle -> next-cycle data_out=16'h1234.
REQ-040 Clear: clr pulse -> busy=1 for 76800 cycles; regwrite during sweep has no effect; afterwards reads of 0, 3, 76799 return INIT_VAL.
REQ-041 Range: write@76800 then read@76800 -> memory unchanged, data_out=0, err=1 until rst.
REQ-042 Reset mid-op: rst 100 cycles into CLEAR -> busy=0 next cycle, addr 99 = INIT_VAL, addr 200 retains prior data.
